// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the down_clk divider configuration sequencer.
package div_ctrl_pkg;

  localparam int unsigned DIV_W_DEFAULT = 16;
  localparam int unsigned DIV_MIN       = 2;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitEdge = 2'd1,
    StReload   = 2'd2,
    StSettle   = 2'd3
  } div_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus a registered falling-edge detect.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/div_cfg_ctrl.sv
// Divisor update sequencer for down_clk: reloads only at a slow_clk falling edge.
// Optional WAIT_EDGE timeout with sticky o_timeout when DIV_CFG_CTRL_TIMEOUT_EN is defined.
module div_cfg_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_CYCLES  = 2
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 131072
`endif
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst,
  input  logic             i_req_valid,
  input  logic [DIV_W-1:0] i_req_divisor,
  output logic             o_req_ready,
  input  logic             i_slow_clk,
  output logic [DIV_W-1:0] o_divisor_reg,
  output logic             o_div_rst,
  output logic             o_busy,
  output logic             o_applied,
  output logic             o_err
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
  ,
  output logic             o_timeout
`endif
);

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  div_state_e       state_q, state_d;
  logic [DIV_W-1:0] pending_q, pending_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
  logic             div_rst_q, div_rst_d;
  logic             applied_q, applied_d;
  logic             err_q, err_d;
  logic             fall;
  logic             handshake;

`ifdef DIV_CFG_CTRL_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_i   (i_wb_clk),
    .rst_i   (i_wb_rst),
    .async_i (i_slow_clk),
    .fall_o  (fall)
  );

  assign o_req_ready = (state_q == StIdle) && !i_wb_rst;
  assign handshake   = i_req_valid && o_req_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    divisor_d = divisor_q;
    rst_cnt_d = rst_cnt_q;
    applied_d = 1'b0;
    err_d     = 1'b0;
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
          timeout_d = 1'b0;
          tmo_cnt_d = '0;
`endif
          if (i_req_divisor < DIV_W'(DIV_MIN)) begin
            err_d = 1'b1;
          end else if (i_req_divisor == divisor_q) begin
            applied_d = 1'b1;
          end else begin
            pending_d = i_req_divisor;
            // A divisor below DIV_MIN means down_clk is not toggling: no edge to wait for.
            state_d   = (divisor_q < DIV_W'(DIV_MIN)) ? StReload : StWaitEdge;
          end
        end
      end
      StWaitEdge: begin
        if (fall) begin
          state_d = StReload;
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
        end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
          state_d   = StReload;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
`endif
        end
      end
      StReload: begin
        if (rst_cnt_q == '0) begin
          state_d = StSettle;
        end else begin
          rst_cnt_d = rst_cnt_q - RstW'(1);
        end
      end
      StSettle: begin
        state_d   = StIdle;
        applied_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Reload entry: the only point where the driven divisor may change.
    if (state_d == StReload && state_q != StReload) begin
      divisor_d = pending_d;
      rst_cnt_d = RstW'(RST_CYCLES - 1);
    end
    div_rst_d = (state_d == StReload);
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      divisor_q <= '0;
      rst_cnt_q <= '0;
      div_rst_q <= 1'b1;
      applied_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      divisor_q <= divisor_d;
      rst_cnt_q <= rst_cnt_d;
      div_rst_q <= div_rst_d;
      applied_q <= applied_d;
      err_q     <= err_d;
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_divisor_reg = divisor_q;
  assign o_div_rst     = div_rst_q;
  assign o_busy        = (state_q != StIdle);
  assign o_applied     = applied_q;
  assign o_err         = err_q;
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
  assign o_timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_div_cfg_ctrl.sv
// Directed self-checking bench for div_cfg_ctrl (DIV_W=16, SYNC_STAGES=2, RST_CYCLES=2).
module tb_div_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] req_div;
  logic        ready;
  logic        slow;
  logic [15:0] divisor;
  logic        div_rst;
  logic        busy;
  logic        applied;
  logic        err;
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
  logic        timeout;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  div_cfg_ctrl #(
    .DIV_W       (16),
    .SYNC_STAGES (2),
    .RST_CYCLES  (2)
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (50)
`endif
  ) dut (
    .i_wb_clk      (clk),
    .i_wb_rst      (rst),
    .i_req_valid   (valid),
    .i_req_divisor (req_div),
    .o_req_ready   (ready),
    .i_slow_clk    (slow),
    .o_divisor_reg (divisor),
    .o_div_rst     (div_rst),
    .o_busy        (busy),
    .o_applied     (applied),
    .o_err         (err)
`ifdef DIV_CFG_CTRL_TIMEOUT_EN
    ,
    .o_timeout     (timeout)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; req_div = '0; slow = 1'b0;

    // 1: reset state and release
    repeat (30) tick();
    chk("rst_div_rst", div_rst, 1);
    chk("rst_divisor", divisor, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_applied", applied, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    chk("rel_div_rst", div_rst, 0);
    chk("rel_ready", ready, 1);
    chk("rel_busy", busy, 0);

    // 2: idle divider, request 4 -> direct reload
    valid = 1'b1; req_div = 16'd4;
    tick();
    valid = 1'b0;
    chk("t2_c1_div_rst", div_rst, 1);
    chk("t2_c1_divisor", divisor, 4);
    chk("t2_c1_ready", ready, 0);
    chk("t2_c1_applied", applied, 0);
    tick();
    chk("t2_c2_div_rst", div_rst, 1);
    chk("t2_c2_applied", applied, 0);
    tick();
    chk("t2_c3_div_rst", div_rst, 0);
    chk("t2_c3_busy", busy, 1);
    chk("t2_c3_applied", applied, 0);
    tick();
    chk("t2_c4_applied", applied, 1);
    chk("t2_c4_busy", busy, 0);
    chk("t2_c4_ready", ready, 1);
    tick();
    chk("t2_c5_applied", applied, 0);

    // 3: running divider, request 101 waits for a slow_clk fall
    slow = 1'b1;
    repeat (5) tick();
    valid = 1'b1; req_div = 16'd101;
    tick();
    valid = 1'b0;
    chk("t3_wait_busy", busy, 1);
    chk("t3_wait_divisor", divisor, 4);
    chk("t3_wait_div_rst", div_rst, 0);
    repeat (10) tick();
    chk("t3_hold_busy", busy, 1);
    chk("t3_hold_divisor", divisor, 4);
    slow = 1'b0;
    tick();
    tick();
    chk("t3_sync_div_rst", div_rst, 0);
    chk("t3_sync_divisor", divisor, 4);
    tick();
    chk("t3_reload_div_rst", div_rst, 1);
    chk("t3_reload_divisor", divisor, 101);
    repeat (3) tick();
    chk("t3_applied", applied, 1);
    chk("t3_done_busy", busy, 0);

    // 4: illegal divisors 0 and 1, back to back
    valid = 1'b1; req_div = 16'd0;
    tick();
    req_div = 16'd1;
    chk("t4_err0", err, 1);
    chk("t4_err0_applied", applied, 0);
    chk("t4_err0_divisor", divisor, 101);
    chk("t4_err0_div_rst", div_rst, 0);
    tick();
    valid = 1'b0;
    chk("t4_err1", err, 1);
    chk("t4_err1_applied", applied, 0);
    chk("t4_err1_divisor", divisor, 101);
    tick();
    chk("t4_err_clear", err, 0);

    // 5: request held while busy, then a same-value request
    slow = 1'b1;
    repeat (4) tick();
    valid = 1'b1; req_div = 16'd5;
    tick();
    req_div = 16'd101;
    chk("t5_wait_ready", ready, 0);
    chk("t5_wait_busy", busy, 1);
    repeat (5) tick();
    chk("t5_held_ready", ready, 0);
    chk("t5_held_divisor", divisor, 101);
    slow = 1'b0;
    repeat (3) tick();
    chk("t5_reload5_divisor", divisor, 5);
    chk("t5_reload5_div_rst", div_rst, 1);
    repeat (3) tick();
    chk("t5_applied5", applied, 1);
    chk("t5_ready_again", ready, 1);
    tick();
    valid = 1'b0;
    chk("t5_taken_busy", busy, 1);
    chk("t5_taken_divisor", divisor, 5);
    slow = 1'b1;
    repeat (4) tick();
    chk("t5_wait101_divisor", divisor, 5);
    slow = 1'b0;
    repeat (3) tick();
    chk("t5_reload101_divisor", divisor, 101);
    repeat (3) tick();
    chk("t5_applied101", applied, 1);
    valid = 1'b1; req_div = 16'd101;
    tick();
    valid = 1'b0;
    chk("t5_same_applied", applied, 1);
    chk("t5_same_div_rst", div_rst, 0);
    chk("t5_same_busy", busy, 0);
    tick();
    chk("t5_same_applied_end", applied, 0);
    chk("t5_same_div_rst_end", div_rst, 0);

    // 6: reset during reload aborts the update
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_pre_divisor", divisor, 0);
    valid = 1'b1; req_div = 16'd9;
    tick();
    valid = 1'b0;
    chk("t6_reload_divisor", divisor, 9);
    rst = 1'b1;
    tick();
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_divisor", divisor, 0);
    chk("t6_abort_applied", applied, 0);
    chk("t6_abort_div_rst", div_rst, 1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_applied", applied, 0);
    end
    chk("t6_ready", ready, 1);
    chk("t6_div_rst_low", div_rst, 0);

`ifdef DIV_CFG_CTRL_TIMEOUT_EN
    // Timeout: slow_clk stuck high forces reload after 50 WAIT_EDGE cycles
    begin
      int n;
      slow = 1'b1;
      valid = 1'b1; req_div = 16'd3;
      tick();
      valid = 1'b0;
      repeat (3) tick();
      chk("tmo_pre_applied", applied, 1);
      valid = 1'b1; req_div = 16'd6;
      tick();
      valid = 1'b0;
      chk("tmo_wait_busy", busy, 1);
      chk("tmo_wait_flag", timeout, 0);
      n = 1;
      while (div_rst !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      chk("tmo_cycles", n, 51);
      chk("tmo_flag", timeout, 1);
      chk("tmo_divisor", divisor, 6);
      repeat (3) tick();
      chk("tmo_applied", applied, 1);
      chk("tmo_sticky", timeout, 1);
      valid = 1'b1; req_div = 16'd6;
      tick();
      valid = 1'b0;
      chk("tmo_clear", timeout, 0);
      chk("tmo_same_applied", applied, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_cfg_ctrl.md
Name: div_cfg_ctrl

Overview:
Configuration sequencer for the down_clk divider in the PWM timer. It accepts divisor update requests from the register file over a valid/ready handshake and rejects illegal divisors (0, 1). Legal updates are applied only at a safe point, the falling edge of slow_clk, by holding the divider in reset for a fixed number of cycles and then releasing it with the new divisor. This keeps every slow_clk high phase full-length and glitch-free across updates.

Parameters:
DIV_W, 16, divisor width; matches down_clk divisor_reg
SYNC_STAGES, 2, flops in the slow_clk synchronizer (minimum 2)
RST_CYCLES, 2, cycles the divider reset is held during a reload (minimum 1)
TIMEOUT_CYC, 131072, WAIT_EDGE timeout in i_wb_clk cycles (used only with the optional feature)

Ports:
i_wb_clk  in  1  system clock
i_wb_rst  in  1  synchronous, active-high reset
i_req_valid  in  1  divisor update request
i_req_divisor  in  DIV_W  requested divisor
o_req_ready  out  1  request accepted when valid && ready
i_slow_clk  in  1  slow_clk fed back from down_clk; asynchronous, synchronized internally
o_divisor_reg  out  DIV_W  divisor driven to down_clk
o_div_rst  out  1  active-high reset to down_clk
o_busy  out  1  high in any state other than IDLE
o_applied  out  1  1-cycle pulse when a new divisor takes effect
o_err  out  1  1-cycle pulse when a request is rejected

Behaviour:
- Reset (synchronous, active-high), checked on i_wb_clk rising edge:
  - state=IDLE, o_divisor_reg=0, o_div_rst=1, o_req_ready=0, o_busy=0, o_applied=0, o_err=0.
  - Synchronizer flops and all counters cleared.
  - First cycle after reset release: o_div_rst=0, o_req_ready=1.
- Reset asserted mid-operation aborts any pending update. o_divisor_reg returns to 0; no o_applied pulse.
- slow_clk path: SYNC_STAGES-flop synchronizer, then edge register. fall = prev & ~cur.
- o_req_ready=1 only in IDLE and not in reset. Handshake = i_req_valid && o_req_ready. Requests while busy are not accepted; the requester holds valid.
- FSM:
  - IDLE, on handshake:
    - i_req_divisor < 2 -> o_err pulse next cycle; o_divisor_reg unchanged; stay IDLE.
    - i_req_divisor == o_divisor_reg -> o_applied pulse next cycle; no reload; stay IDLE.
    - else latch pending=i_req_divisor.
      - If o_divisor_reg < 2 (divider idle) -> RELOAD.
      - Otherwise -> WAIT_EDGE.
  - WAIT_EDGE: on fall -> RELOAD. A fall in the handshake cycle itself is ignored; detection starts the cycle after entry.
  - RELOAD:
    - Entry cycle: o_divisor_reg<=pending, o_div_rst<=1, rst counter loaded RST_CYCLES-1.
    - o_div_rst stays high exactly RST_CYCLES cycles; then -> SETTLE.
  - SETTLE: o_div_rst=0, o_applied pulses for 1 cycle, -> IDLE (o_req_ready=1 the next cycle).
- Latency:
  - Idle divider: handshake to o_applied = RST_CYCLES+2 cycles.
  - Active divider: synchronizer delay + wait for next slow_clk fall + RST_CYCLES+2.
- o_err and o_applied are never high in the same cycle. Both are registered outputs.
- o_divisor_reg changes only on the RELOAD entry cycle or on reset.
- Divisor compare is unsigned, DIV_W bits. No arithmetic on the divisor.

Optional Feature:
Macro DIV_CFG_CTRL_TIMEOUT_EN.
- Defined: a counter runs in WAIT_EDGE. If TIMEOUT_CYC cycles pass with no fall, force a transition to RELOAD and set sticky status o_timeout (extra output port, 1 bit). o_timeout clears on reset or on the next accepted handshake.
- Undefined: no counter and no o_timeout port. WAIT_EDGE waits for a fall indefinitely.

Decomposition:
- Shared package div_ctrl_pkg holds:
  - state encoding: IDLE=0, WAIT_EDGE=1, RELOAD=2, SETTLE=3;
  - DIV_MIN=2;
  - default DIV_W.
- One sub-module: sync_edge_det (SYNC_STAGES-flop synchronizer plus falling-edge detect), reusable elsewhere in the timer.

Test Plan:
1. Reset for 30 cycles, then release -> o_divisor_reg=0 and o_div_rst=1 during reset; o_div_rst=0 and o_req_ready=1 one cycle after release; o_busy=0.
2. From reset state, request divisor 4 -> no WAIT_EDGE. o_div_rst high for exactly 2 cycles; o_divisor_reg=4; o_applied pulses RST_CYCLES+2 cycles after the handshake.
3. Divider running at 4, request 101 with i_slow_clk driven high -> stays in WAIT_EDGE, o_busy=1, o_divisor_reg=4. Drop i_slow_clk -> RELOAD entered SYNC_STAGES+1 cycles later, o_divisor_reg=101, then o_applied pulses.
4. Request 0, then request 1 -> o_err pulses each time; o_divisor_reg and o_div_rst unchanged; no o_applied.
5. While in WAIT_EDGE, hold i_req_valid with 5 -> o_req_ready=0, request not taken until IDLE. Same-value request 101 -> o_applied with no o_div_rst pulse.
6. Assert i_wb_rst during RELOAD -> next cycle state=IDLE, o_divisor_reg=0, no o_applied. With DIV_CFG_CTRL_TIMEOUT_EN and TIMEOUT_CYC=50: i_slow_clk stuck high -> forced RELOAD after 50 cycles, o_timeout=1.
